// File: rtl/dct8_pipe.sv
// dct8_pipe: 4-stage pipelined 8-point forward integer DCT (binDCT-style lifting, shift/add only).
// Optional JPEG level shift for unsigned inputs is enabled by defining DCT8_LEVEL_SHIFT_EN.
module dct8_pipe #(
  parameter int IN_W      = 8,
  parameter int IN_SIGNED = 0,
  parameter int OUT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [8*IN_W-1:0]         x_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic signed [8*OUT_W-1:0] y_out
);

  typedef logic signed [OUT_W-1:0] word_t;

`ifdef DCT8_LEVEL_SHIFT_EN
  localparam word_t LVL_OFS = word_t'(1) << (IN_W - 1);
`endif

  word_t w_x [8];
  word_t w_a [8];
  word_t w_b [8];
  word_t w_c [8];
  word_t w_y [8];

  word_t r_a [8];
  word_t r_b [8];
  word_t r_c [8];
  word_t r_y [8];

  logic r_v1, r_v2, r_v3, r_v4;
  logic r_l1, r_l2, r_l3, r_l4;
  logic w_adv;

  // The whole pipe moves as one; a stalled output freezes every stage behind it.
  assign w_adv     = !r_v4 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v4;
  assign out_last  = r_l4;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [IN_W-1:0] w_raw;
      word_t           w_ext;
      assign w_raw = x_in[gi*IN_W +: IN_W];
      assign w_ext = (IN_SIGNED != 0) ? word_t'({{(OUT_W-IN_W){w_raw[IN_W-1]}}, w_raw})
                                      : word_t'({{(OUT_W-IN_W){1'b0}}, w_raw});
`ifdef DCT8_LEVEL_SHIFT_EN
      assign w_x[gi] = (IN_SIGNED == 0) ? (w_ext - LVL_OFS) : w_ext;
`else
      assign w_x[gi] = w_ext;
`endif
      assign y_out[gi*OUT_W +: OUT_W] = r_y[gi];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_a[i]   = w_x[i] + w_x[7-i];
      w_a[4+i] = w_x[3-i] - w_x[4+i];
    end
  end

  // Lifting rotation on the odd pair (a5, a6); b6 uses the original a5, not b5.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_b[i] = r_a[i];
    end
    w_b[5] = ((r_a[6] >>> 3) + (r_a[6] >>> 1)) - r_a[5];
    w_b[6] = ((r_a[5] >>> 3) + (r_a[5] >>> 2)) + r_a[6];
  end

  always_comb begin
    w_c[0] = r_b[0] + r_b[3];
    w_c[1] = r_b[1] + r_b[2];
    w_c[2] = r_b[1] - r_b[2];
    w_c[3] = r_b[0] - r_b[3];
    w_c[4] = r_b[4] + r_b[5];
    w_c[5] = r_b[4] - r_b[5];
    w_c[6] = r_b[7] - r_b[6];
    w_c[7] = r_b[7] + r_b[6];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_y[i] = '0;
    end
    w_y[0] = r_c[0] + r_c[1];
    w_y[1] = (w_y[0] >>> 1) - r_c[1];
    w_y[2] = ((r_c[3] >>> 3) + (r_c[3] >>> 2)) - r_c[2];
    w_y[3] = ((w_y[2] >>> 3) + (w_y[2] >>> 2)) + r_c[3];
    w_y[4] = r_c[4] - (r_c[7] >>> 3);
    w_y[5] = ((r_c[6] >>> 3) + (r_c[6] >>> 2) + (r_c[6] >>> 1)) + r_c[5];
    w_y[6] = r_c[6] - (w_y[5] >>> 1);
    w_y[7] = r_c[7];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
      r_l3 <= 1'b0;
      r_l4 <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_c[i] <= '0;
        r_y[i] <= '0;
      end
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
      r_l1 <= in_last;
      r_l2 <= r_l1;
      r_l3 <= r_l2;
      r_l4 <= r_l3;
      for (int i = 0; i < 8; i++) begin
        r_a[i] <= w_a[i];
        r_b[i] <= w_b[i];
        r_c[i] <= w_c[i];
        r_y[i] <= w_y[i];
      end
    end
  end

endmodule

// File: tb/tb_dct8_pipe.sv
// tb_dct8_pipe: directed vectors with a scoreboard fed by an arithmetic DCT model.
// Expectations follow DCT8_LEVEL_SHIFT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dct8_pipe;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;

  typedef int vec_t [8];
  typedef struct packed {
    logic [8*OUT_W-1:0] y;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n, in_valid, in_ready, in_last;
  logic                      out_valid, out_ready, out_last;
  logic [8*IN_W-1:0]         x_in;
  logic signed [8*OUT_W-1:0] y_out;

  logic                      s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_last;
  logic [8*IN_W-1:0]         s_x_in;
  logic signed [8*OUT_W-1:0] s_y_out;

  int   nChecks = 0;
  int   nFails  = 0;
  int   popped  = 0;
  logic lastSeen = 1'b0;
  exp_t q[$];
  exp_t mE;
  exp_t mIn;
  logic [8*OUT_W-1:0] prevY;
  logic prevHold = 1'b0;

  dct8_pipe #(.IN_W(IN_W), .IN_SIGNED(0), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .y_out(y_out)
  );

  dct8_pipe #(.IN_W(IN_W), .IN_SIGNED(1), .OUT_W(OUT_W)) u_dutS (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(s_in_last),
    .x_in(s_x_in), .out_valid(s_out_valid), .out_ready(1'b1), .out_last(s_out_last), .y_out(s_y_out)
  );

  task automatic checkOutput(input string name, input logic [8*OUT_W-1:0] act,
                             input logic [8*OUT_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int wr(input int v);
    logic signed [OUT_W-1:0] t;
    t = v[OUT_W-1:0];
    return int'(t);
  endfunction

  function automatic logic [8*OUT_W-1:0] packY(input vec_t y);
    logic [8*OUT_W-1:0] p;
    for (int i = 0; i < 8; i++) p[i*OUT_W +: OUT_W] = y[i][OUT_W-1:0];
    return p;
  endfunction

  function automatic logic [8*IN_W-1:0] packX(input vec_t xs);
    logic [8*IN_W-1:0] p;
    for (int i = 0; i < 8; i++) p[i*IN_W +: IN_W] = xs[i][IN_W-1:0];
    return p;
  endfunction

  function automatic vec_t unpackX(input logic [8*IN_W-1:0] p);
    vec_t xs;
    for (int i = 0; i < 8; i++) xs[i] = int'(p[i*IN_W +: IN_W]);
    return xs;
  endfunction

  function automatic vec_t stallVec(input int idx);
    vec_t xs;
    for (int j = 0; j < 8; j++) xs[j] = (idx * 37 + j * 19 + (j * j) * 11) & 255;
    return xs;
  endfunction

  // Inputs are raw IN_W-bit codes; the model applies extension and level shift itself.
  function automatic logic [8*OUT_W-1:0] dctModel(input vec_t xs, input bit isSigned);
    vec_t v, a, b, c, y;
    logic signed [IN_W-1:0] sb;
    for (int i = 0; i < 8; i++) begin
      sb   = xs[i][IN_W-1:0];
      v[i] = isSigned ? int'(sb) : (xs[i] & ((1 << IN_W) - 1));
`ifdef DCT8_LEVEL_SHIFT_EN
      if (!isSigned) v[i] = v[i] - (1 << (IN_W - 1));
`endif
    end
    for (int i = 0; i < 4; i++) begin
      a[i]   = wr(v[i] + v[7-i]);
      a[4+i] = wr(v[3-i] - v[4+i]);
    end
    b    = a;
    b[5] = wr((a[6] >>> 3) + (a[6] >>> 1) - a[5]);
    b[6] = wr((a[5] >>> 3) + (a[5] >>> 2) + a[6]);
    c[0] = wr(b[0] + b[3]);  c[1] = wr(b[1] + b[2]);
    c[2] = wr(b[1] - b[2]);  c[3] = wr(b[0] - b[3]);
    c[4] = wr(b[4] + b[5]);  c[5] = wr(b[4] - b[5]);
    c[6] = wr(b[7] - b[6]);  c[7] = wr(b[7] + b[6]);
    y[0] = wr(c[0] + c[1]);
    y[1] = wr((y[0] >>> 1) - c[1]);
    y[2] = wr((c[3] >>> 3) + (c[3] >>> 2) - c[2]);
    y[3] = wr((y[2] >>> 3) + (y[2] >>> 2) + c[3]);
    y[4] = wr(c[4] - (c[7] >>> 3));
    y[5] = wr((c[6] >>> 3) + (c[6] >>> 2) + (c[6] >>> 1) + c[5]);
    y[6] = wr(c[6] - (y[5] >>> 1));
    y[7] = c[7];
    return packY(y);
  endfunction

  // Scoreboard: every accepted input queues its model result; every accepted output must match.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prevHold = 1'b0;
    end else begin
      checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prevHold) begin
        checkOutput("hold_y", y_out, prevY);
        checkOutput("hold_valid", out_valid, 1);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          checkOutput("stale_output", out_valid, 0);
        end else if (out_ready) begin
          mE = q.pop_front();
          checkOutput("sb_y", y_out, mE.y);
          checkOutput("sb_last", out_last, mE.last);
          lastSeen = out_last;
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        mIn.y    = dctModel(unpackX(x_in), 1'b0);
        mIn.last = in_last;
        q.push_back(mIn);
      end
      prevHold = out_valid && !out_ready;
      prevY    = y_out;
    end
  end

  task automatic applyStimulus(input vec_t xs, input logic last);
    in_valid = 1'b1;
    x_in     = packX(xs);
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkLatency(input string name, input vec_t lit);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput(name, y_out, packY(lit));
    @(posedge clk);
    #1;
    checkOutput({name, "_pulse"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t xs, lit;
    int   idx, popBase;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; x_in = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_x_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_y_out", y_out, '0);
    rst_n = 1'b1;
    checkOutput("reset_in_ready", in_ready, 1);

`ifdef DCT8_LEVEL_SHIFT_EN
    xs = '{128, 128, 128, 128, 128, 128, 128, 128};
    lit = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkOutput("model_128", dctModel(xs, 1'b0), packY(lit));
    applyStimulus(xs, 1'b0);
    checkLatency("ls_128", lit);
    xs = '{129, 129, 129, 129, 129, 129, 129, 129};
    lit = '{8, 0, 0, 0, 0, 0, 0, 0};
    checkOutput("model_129", dctModel(xs, 1'b0), packY(lit));
    applyStimulus(xs, 1'b0);
    checkLatency("ls_129", lit);
`else
    xs = '{1, 1, 1, 1, 1, 1, 1, 1};
    lit = '{8, 0, 0, 0, 0, 0, 0, 0};
    checkOutput("model_ones", dctModel(xs, 1'b0), packY(lit));
    applyStimulus(xs, 1'b0);
    checkLatency("ones", lit);
    xs = '{0, 1, 2, 3, 4, 5, 6, 7};
    lit = '{28, 0, 0, 0, 0, 0, 0, -14};
    checkOutput("model_ramp", dctModel(xs, 1'b0), packY(lit));
    applyStimulus(xs, 1'b0);
    checkLatency("ramp", lit);
    xs = '{255, 255, 255, 255, 255, 255, 255, 255};
    lit = '{2040, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(xs, 1'b0);
    checkLatency("max255", lit);
`endif

    // Ten back-to-back vectors with the sink stalling on cycles 5..7.
    idx = 0;
    popBase = popped;
    for (int k = 0; k < 40 && idx < 10; k++) begin
      out_ready = !(k >= 5 && k <= 7);
      in_valid  = 1'b1;
      x_in      = packX(stallVec(idx));
      in_last   = (idx == 9);
      @(negedge clk);
      if (k >= 5 && k <= 7) checkOutput("stall_in_ready", in_ready, 0);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("stall_accepted", idx, 10);
    checkOutput("stall_emitted", popped - popBase, 10);
    checkOutput("stall_last", lastSeen, 1);

    // Reset with three vectors in flight must discard them all.
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      x_in = packX(stallVec(n + 20));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_y", y_out, '0);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_no_stale", out_valid, 0);
    end

    // Signed instance: all lanes -1, then a mixed vector against the model.
    xs = '{-1, -1, -1, -1, -1, -1, -1, -1};
    lit = '{-8, 0, 0, 0, 0, 0, 0, 0};
    checkOutput("model_neg1", dctModel(xs, 1'b1), packY(lit));
    s_in_valid = 1'b1; s_x_in = packX(xs);
    @(posedge clk);
    #1;
    xs = '{-128, 127, -5, 60, -77, 3, 100, -1};
    s_x_in = packX(xs);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("signed_valid", s_out_valid, 1);
    checkOutput("signed_neg1", s_y_out, packY(lit));
    @(posedge clk);
    #1;
    checkOutput("signed_mixed", s_y_out, dctModel(xs, 1'b1));
    @(posedge clk);
    #1;
    checkOutput("signed_pulse", s_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dct8_pipe.md
Name: dct8_pipe

Overview:
- Pipelined, parametrised 8-point forward 1-D integer DCT using binDCT-style lifting with shift/add only.
- Accepts one 8-sample vector per cycle through a valid/ready handshake and produces 8 coefficients after a fixed 4-stage latency.
- Used twice in the JPEG path: row pass with unsigned pixels, column pass with signed row results. A `last` sideband marks block boundaries.

Parameters:
- IN_W, 8, input sample width.
- IN_SIGNED, 0, 0 = inputs unsigned (zero-extended), 1 = inputs signed (sign-extended).
- OUT_W, 16, internal and output width (two's complement); must be ≥ IN_W+4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input this cycle.
- in_last  in  1  sideband, carried alongside the vector.
- x_in  in  8×IN_W  samples x[0..7].
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  delayed in_last.
- y_out  out  8×OUT_W signed  coefficients y[0..7].

Behaviour:
- **Reset** (rst_n=0 at posedge): all stage valids, out_valid, out_last and y_out clear to 0. in_ready=1 in the first cycle after reset. Reset mid-operation discards every in-flight vector; nothing is emitted afterwards.
- **Pipeline:** 4 register stages S1..S4. S4 drives the outputs.
- **Advance and backpressure:**
  - adv = !out_valid | out_ready.
  - in_ready = adv, combinational from out_ready.
  - When adv=1, all stages shift one step and S1 captures x_in with valid = in_valid.
  - When adv=0, every stage and the outputs hold; a held output stays stable until accepted.
- **Latency and throughput:**
  - Latency 4 cycles: an input accepted in cycle n appears at cycle n+4 with no stalls, +1 for each stall cycle.
  - Throughput 1 vector/cycle. Bubbles (in_valid=0) propagate as invalid slots.
- **Width and arithmetic:**
  - Inputs are extended to OUT_W per IN_SIGNED.
  - All arithmetic is OUT_W two's complement, wrapping on overflow.
  - `>>>` is an arithmetic shift right (floor).
  - Every shift is applied to its operand before addition; parenthesisation is exactly as written below.
- **S1:** for i=0..3: a[i]=x[i]+x[7-i]; a[4+i]=x[3-i]-x[4+i].
- **S2:**
  - b5=((a6>>>3)+(a6>>>1))-a5.
  - b6=((a5>>>3)+(a5>>>2))+a6.
  - Others pass through: b[k]=a[k].
- **S3:**
  - c0=b0+b3; c1=b1+b2; c2=b1-b2; c3=b0-b3.
  - c4=b4+b5; c5=b4-b5; c6=b7-b6; c7=b7+b6.
- **S4:**
  - y0=c0+c1; y1=(y0>>>1)-c1.
  - y2=((c3>>>3)+(c3>>>2))-c2; y3=((y2>>>3)+(y2>>>2))+c3.
  - y4=c4-(c7>>>3); y5=((c6>>>3)+(c6>>>2)+(c6>>>1))+c5.
  - y6=c6-(y5>>>1); y7=c7.
- **Sideband:** in_last travels with its vector and is registered identically to the data valid.
- **Simultaneous events:** when out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the output is consumed and the input accepted; no slot is lost.

Optional Feature:
- Macro DCT8_LEVEL_SHIFT_EN.
- When defined and IN_SIGNED=0: each input has 2^(IN_W-1) subtracted after zero-extension and before S1 (JPEG level shift). Latency is unchanged.
- When undefined, or when IN_SIGNED=1: no shift is applied.

Test Plan:
- All x=1, IN_W=8, unsigned, no stall → after 4 cycles y={8,0,0,0,0,0,0,0}, out_valid pulses 1 cycle.
- x={0,1,2,3,4,5,6,7} → y={28,0,0,0,0,0,0,-14}. All x=255 → y0=2040, y1..y7=0.
- 10 back-to-back vectors with out_ready low on cycles 5–7 → in_ready low those cycles, outputs held stable, all 10 results emitted in order with none lost or duplicated. out_last matches in_last on vector 10.
- rst_n=0 for 1 cycle while 3 vectors are in flight → out_valid=0 and y_out=0 the next cycle, no stale output afterwards.
- IN_SIGNED=1, x=-1 on all lanes → y0=-8, y1=(-8>>>1)+4=0, others 0.
- DCT8_LEVEL_SHIFT_EN defined, all x=128 → y all 0. All x=129 → y0=8, others 0.
